// File: rtl/bus_grant_scheduler.sv
// Two-master / three-slave bus grant scheduler with round-robin arbitration,
// serial slave-select decode and a ready timeout. Define BUS_GRANT_SPLIT_EN for split transactions.
module bus_grant_scheduler #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic       m1_addr,
    input  logic       m2_addr,
    input  logic       m1_addr_valid,
    input  logic       m2_addr_valid,
    input  logic       s1_ready,
    input  logic       s2_ready,
    input  logic       s3_ready,
    input  logic       s1_hold,
    input  logic       s2_hold,
    input  logic       s3_hold,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic [2:0] slave_en,
    output logic [1:0] slave_sel,
    output logic       bus_busy,
    output logic       error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WAIT    = 3'd2,
        S_CONNECT = 3'd3,
        S_RELEASE = 3'd4,
        S_SPLIT   = 3'd5
    } state_t;

    state_t     st;
    logic       owner;       // 0 = m1, 1 = m2
    logic       last_owner;
    logic       addr_msb;
    logic       addr_cnt;
    logic [7:0] tcnt;

    logic       own_req, own_addr, own_valid;
    logic       sel_ready;
    logic       elig1, elig2, pick_m2;
    logic [1:0] code;

    assign own_req   = owner ? m2_request    : m1_request;
    assign own_addr  = owner ? m2_addr       : m1_addr;
    assign own_valid = owner ? m2_addr_valid : m1_addr_valid;
    assign sel_ready = |({s3_ready, s2_ready, s1_ready} & slave_en);
    assign code      = {addr_msb, own_addr};

    function automatic logic [2:0] onehot(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

`ifdef BUS_GRANT_SPLIT_EN
    logic       split_pend;
    logic       split_owner;
    logic [1:0] split_slave;
    logic       sel_hold;
    logic [1:0] cur_idx;
    logic [2:0] hold_vec;

    assign hold_vec = {s3_hold, s2_hold, s1_hold};
    assign sel_hold = |(hold_vec & slave_en);
    assign cur_idx  = slave_en[2] ? 2'd2 : (slave_en[1] ? 2'd1 : 2'd0);
    // A parked split owner may not re-arbitrate; it is resumed by hold release.
    assign elig1 = m1_request && !(split_pend && !split_owner);
    assign elig2 = m2_request && !(split_pend && split_owner);
`else
    logic unused_hold;
    assign unused_hold = s1_hold ^ s2_hold ^ s3_hold;
    assign elig1 = m1_request;
    assign elig2 = m2_request;
`endif

    // On a tie, the master that did not own the bus last wins.
    assign pick_m2 = elig2 && (!elig1 || !last_owner);

    assign state    = st;
    assign bus_busy = (st != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            addr_msb   <= 1'b0;
            addr_cnt   <= 1'b0;
            tcnt       <= 8'd0;
            m1_grant   <= 1'b0;
            m2_grant   <= 1'b0;
            slave_en   <= 3'b000;
            slave_sel  <= 2'd0;
            error      <= 1'b0;
`ifdef BUS_GRANT_SPLIT_EN
            split_pend  <= 1'b0;
            split_owner <= 1'b0;
            split_slave <= 2'd0;
`endif
        end else begin
            error <= 1'b0;
            case (st)
                S_IDLE: begin
`ifdef BUS_GRANT_SPLIT_EN
                    if (split_pend && !hold_vec[split_slave]) begin
                        st         <= S_CONNECT;
                        owner      <= split_owner;
                        m1_grant   <= !split_owner;
                        m2_grant   <= split_owner;
                        slave_en   <= onehot(split_slave);
                        split_pend <= 1'b0;
                    end else
`endif
                    if (elig1 || elig2) begin
                        st       <= S_ADDR;
                        owner    <= pick_m2;
                        m1_grant <= !pick_m2;
                        m2_grant <= pick_m2;
                        addr_msb <= 1'b0;
                        addr_cnt <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (!own_req) begin
                        st       <= S_RELEASE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                    end else if (own_valid) begin
                        if (!addr_cnt) begin
                            addr_msb <= own_addr;
                            addr_cnt <= 1'b1;
                        end else if (code == 2'b11) begin
                            st       <= S_RELEASE;
                            error    <= 1'b1;
                            m1_grant <= 1'b0;
                            m2_grant <= 1'b0;
                        end else begin
                            st        <= S_WAIT;
                            slave_en  <= onehot(code);
                            slave_sel <= code;
                            tcnt      <= 8'd0;
                        end
                    end
                end
                S_WAIT: begin
                    if (!own_req) begin
                        st       <= S_RELEASE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        slave_en <= 3'b000;
                    end else if (sel_ready) begin
                        st <= S_CONNECT;
                    end else if (tcnt == TIMEOUT - 8'd1) begin
                        st       <= S_RELEASE;
                        error    <= 1'b1;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        slave_en <= 3'b000;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_CONNECT: begin
                    if (!own_req) begin
                        st       <= S_RELEASE;
                        m1_grant <= 1'b0;
                        m2_grant <= 1'b0;
                        slave_en <= 3'b000;
                    end
`ifdef BUS_GRANT_SPLIT_EN
                    else if (sel_hold) begin
                        st          <= S_SPLIT;
                        m1_grant    <= 1'b0;
                        m2_grant    <= 1'b0;
                        slave_en    <= 3'b000;
                        split_pend  <= 1'b1;
                        split_owner <= owner;
                        split_slave <= cur_idx;
                    end
`endif
                end
                S_RELEASE: begin
                    last_owner <= owner;
                    st         <= S_IDLE;
                end
`ifdef BUS_GRANT_SPLIT_EN
                S_SPLIT: begin
                    st <= S_IDLE;
                end
`endif
                default: begin
                    st       <= S_IDLE;
                    m1_grant <= 1'b0;
                    m2_grant <= 1'b0;
                    slave_en <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_grant_scheduler.sv
// Scoreboard bench for bus_grant_scheduler: expected state transitions are queued
// ahead of the stimulus and a negedge monitor checks each transition as it happens.
module tb_bus_grant_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       m1_request, m2_request, m1_addr, m2_addr, m1_addr_valid, m2_addr_valid;
    logic       s1_ready, s2_ready, s3_ready, s1_hold, s2_hold, s3_hold;
    logic       m1_grant, m2_grant, bus_busy, error;
    logic [2:0] slave_en, state;
    logic [1:0] slave_sel;

    localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, WAIT = 3'd2, CONN = 3'd3, REL = 3'd4, SPLIT = 3'd5;

    bus_grant_scheduler #(.TIMEOUT(8'd200)) dut (
        .clk(clk), .reset(reset),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_addr(m1_addr), .m2_addr(m2_addr),
        .m1_addr_valid(m1_addr_valid), .m2_addr_valid(m2_addr_valid),
        .s1_ready(s1_ready), .s2_ready(s2_ready), .s3_ready(s3_ready),
        .s1_hold(s1_hold), .s2_hold(s2_hold), .s3_hold(s3_hold),
        .m1_grant(m1_grant), .m2_grant(m2_grant),
        .slave_en(slave_en), .slave_sel(slave_sel),
        .bus_busy(bus_busy), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       g1, g2;
        logic [2:0] en;
        logic [1:0] sel;
        logic       err;
        int         dwell;   // cycles spent in the previous state, -1 = don't care
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;

    task automatic push(input logic [2:0] s, input logic g1, input logic g2,
                        input logic [2:0] en, input logic [1:0] sel, input logic err, input int dwell);
        exp_t e;
        e.st = s; e.g1 = g1; e.g2 = g2; e.en = en; e.sel = sel; e.err = err; e.dwell = dwell;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input bit m, input logic v, input logic a);
        if (m) begin m2_addr_valid = v; m2_addr = a; end
        else   begin m1_addr_valid = v; m1_addr = a; end
    endtask

    // Called one cycle after the grant edge, i.e. while the FSM sits in ADDR.
    task automatic send_addr(input bit m, input logic b1, input logic b0, input bit gap);
        set_addr(m, 1'b1, b1); cyc(1);
        if (gap) begin set_addr(m, 1'b0, 1'b0); cyc(1); end
        set_addr(m, 1'b1, b0); cyc(1);
        set_addr(m, 1'b0, 1'b0);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && state !== s; i++) cyc(1);
        if (state !== s) begin
            n_chk++;
            $display("FAIL wait_state: state=%0d never reached %0d within %0d cycles", state, s, budget);
        end
    endtask

    task automatic chk_zero(input string name);
        logic [11:0] act;
        act = {state, m1_grant, m2_grant, slave_en, slave_sel, bus_busy, error};
        n_chk++;
        if (act === 12'd0) n_pass++;
        else $display("FAIL %s: outputs {state,g1,g2,en,sel,busy,err}=%b want all zero", name, act);
    endtask

    // Monitor: every state change consumes one scoreboard entry.
    initial begin
        logic [2:0] prev;
        int         cnt;
        exp_t       e;
        bit         ok;
        wait (mon_on);
        prev = state;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (state !== prev) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_transition: %0d -> %0d with nothing expected", prev, state);
                end else begin
                    e  = q.pop_front();
                    ok = (state === e.st) && (m1_grant === e.g1) && (m2_grant === e.g2) &&
                         (slave_en === e.en) && (slave_sel === e.sel) && (error === e.err) &&
                         (bus_busy === (e.st != IDLE)) && (e.dwell < 0 || cnt == e.dwell);
                    if (ok) n_pass++;
                    else $display("FAIL transition %0d->%0d: got st=%0d g1=%b g2=%b en=%b sel=%0d err=%b busy=%b dwell=%0d, want st=%0d g1=%b g2=%b en=%b sel=%0d err=%b dwell=%0d",
                                  prev, state, state, m1_grant, m2_grant, slave_en, slave_sel, error, bus_busy, cnt,
                                  e.st, e.g1, e.g2, e.en, e.sel, e.err, e.dwell);
                end
                prev = state;
                cnt  = 1;
            end else begin
                cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {m1_request, m2_request, m1_addr, m2_addr, m1_addr_valid, m2_addr_valid} = '0;
        {s1_ready, s2_ready, s3_ready, s1_hold, s2_hold, s3_hold} = '0;
        cyc(3);
        chk_zero("reset_state");
        reset = 1'b0;
        mon_on = 1'b1;
        cyc(2);

        // m1 alone to s2, ready after 3 WAIT cycles, then release.
        push(ADDR, 1, 0, 3'b000, 0, 0, -1);
        push(WAIT, 1, 0, 3'b010, 1, 0, 2);
        push(CONN, 1, 0, 3'b010, 1, 0, 3);
        push(REL,  0, 0, 3'b000, 1, 0, 4);
        push(IDLE, 0, 0, 3'b000, 1, 0, 1);
        m1_request = 1; cyc(1);
        send_addr(0, 0, 1, 0);
        cyc(2); s2_ready = 1; cyc(1);
`ifndef BUS_GRANT_SPLIT_EN
        s2_hold = 1;
`endif
        cyc(3);
        s2_hold = 0; m1_request = 0; cyc(1);
        s2_ready = 0; cyc(3);

        // Reset restores m1 priority; tie -> m1, then m1 re-request vs m2 -> m2.
        reset = 1; cyc(2);
        chk_zero("reset_idle");
        reset = 0; cyc(1);
        push(ADDR, 1, 0, 3'b000, 0, 0, -1);
        push(WAIT, 1, 0, 3'b001, 0, 0, 3);
        push(CONN, 1, 0, 3'b001, 0, 0, 1);
        push(REL,  0, 0, 3'b000, 0, 0, 1);
        push(IDLE, 0, 0, 3'b000, 0, 0, 1);
        push(ADDR, 0, 1, 3'b000, 0, 0, 1);
        push(WAIT, 0, 1, 3'b100, 2, 0, 2);
        push(CONN, 0, 1, 3'b100, 2, 0, 1);
        push(REL,  0, 0, 3'b000, 2, 0, 1);
        push(IDLE, 0, 0, 3'b000, 2, 0, 1);
        s1_ready = 1; m1_request = 1; m2_request = 1; cyc(1);
        send_addr(0, 0, 0, 1);
        cyc(1);
        m1_request = 0; cyc(1);
        m1_request = 1; cyc(1);
        cyc(1);
        s1_ready = 0; s3_ready = 1;
        send_addr(1, 1, 0, 0);
        cyc(1);
        m1_request = 0; m2_request = 0; cyc(2);
        s3_ready = 0; cyc(2);

        // Bad address 11: one-cycle error, straight to RELEASE.
        push(ADDR, 1, 0, 3'b000, 2, 0, -1);
        push(REL,  0, 0, 3'b000, 2, 1, 2);
        push(IDLE, 0, 0, 3'b000, 2, 0, 1);
        m1_request = 1; cyc(1);
        send_addr(0, 1, 1, 0);
        m1_request = 0; cyc(3);

        // s3 never ready: error after exactly 200 WAIT cycles.
        push(ADDR, 1, 0, 3'b000, 2, 0, -1);
        push(WAIT, 1, 0, 3'b100, 2, 0, 2);
        push(REL,  0, 0, 3'b000, 2, 1, 200);
        push(IDLE, 0, 0, 3'b000, 2, 0, 1);
        m1_request = 1; cyc(1);
        send_addr(0, 1, 0, 0);
        wait_state(REL, 300);
        m1_request = 0; cyc(3);

        // Reset while m2 waits on s2; following tie goes to m1, abort in ADDR has no error.
        push(ADDR, 0, 1, 3'b000, 2, 0, -1);
        push(WAIT, 0, 1, 3'b010, 1, 0, 2);
        push(IDLE, 0, 0, 3'b000, 0, 0, 4);
        push(ADDR, 1, 0, 3'b000, 0, 0, 1);
        push(REL,  0, 0, 3'b000, 0, 0, 1);
        push(IDLE, 0, 0, 3'b000, 0, 0, 1);
        m2_request = 1; cyc(1);
        send_addr(1, 0, 1, 0);
        cyc(3);
        reset = 1; m1_request = 1; cyc(1);
        chk_zero("reset_in_wait");
        reset = 0; cyc(1);
        m1_request = 0; m2_request = 0; cyc(2);
        cyc(2);

`ifdef BUS_GRANT_SPLIT_EN
        // m1 splits on s1, m2 runs a full s3 transaction, hold release resumes m1.
        push(ADDR,  1, 0, 3'b000, 0, 0, -1);
        push(WAIT,  1, 0, 3'b001, 0, 0, 2);
        push(CONN,  1, 0, 3'b001, 0, 0, 1);
        push(SPLIT, 0, 0, 3'b000, 0, 0, 1);
        push(IDLE,  0, 0, 3'b000, 0, 0, 1);
        push(ADDR,  0, 1, 3'b000, 0, 0, 1);
        push(WAIT,  0, 1, 3'b100, 2, 0, 2);
        push(CONN,  0, 1, 3'b100, 2, 0, 1);
        push(REL,   0, 0, 3'b000, 2, 0, 1);
        push(IDLE,  0, 0, 3'b000, 2, 0, 1);
        push(CONN,  1, 0, 3'b001, 2, 0, 3);
        push(REL,   0, 0, 3'b000, 2, 0, 1);
        push(IDLE,  0, 0, 3'b000, 2, 0, 1);
        s1_ready = 1; m1_request = 1; cyc(1);
        send_addr(0, 0, 0, 0);
        cyc(1);
        s1_hold = 1; m2_request = 1; cyc(1);
        cyc(1);
        cyc(1);
        s3_ready = 1;
        send_addr(1, 1, 0, 0);
        cyc(1);
        m2_request = 0; cyc(1);
        cyc(1);
        cyc(2);
        s1_hold = 0; cyc(1);
        m1_request = 0; cyc(1);
        cyc(1);
        s1_ready = 0; s3_ready = 0;
`endif

        cyc(4);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d expected transitions never seen, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_grant_scheduler.md
BUS_GRANT_SCHEDULER -- requirements
Module: bus_grant_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd200: maximum cycles spent waiting for slave ready.
REQ-002 The block SHALL have one clock and a synchronous active-high reset.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- m1_request, m2_request  in  1 each  master bus request, held for whole transaction
- m1_addr, m2_addr  in  1 each  serial slave-select bit, MSB first
- m1_addr_valid, m2_addr_valid  in  1 each  qualifies the addr bit
- s1_ready, s2_ready, s3_ready  in  1 each  slave ready
- s1_hold, s2_hold, s3_hold  in  1 each  slave split request
- m1_grant, m2_grant  out  1 each  bus owned by that master
- slave_en  out  3  one-hot slave connect, bit0 = s1
- slave_sel  out  2  decoded slave index, 0..2
- bus_busy  out  1  high in any state except IDLE
- error  out  1  one-cycle pulse on bad address or timeout
- state  out  3  current FSM state encoding

Function
REQ-004 States SHALL be IDLE=0, ADDR=1, WAIT=2, CONNECT=3, RELEASE=4, SPLIT=5; codes 6 and 7 SHALL go to IDLE.
REQ-005 IDLE: on any eligible request, the FSM SHALL pick a winner and enter ADDR next cycle; the winner's grant SHALL rise on that same edge.
REQ-006 Both requesting: the winner SHALL be the master not granted last (round robin); a single requester SHALL win immediately.
REQ-007 ADDR: the FSM SHALL shift in exactly 2 bits of the granted master's addr, only on cycles with its addr_valid high; there SHALL be no timeout in ADDR.
REQ-008 Decode: 00 selects s1, 01 s2, 10 s3, and the FSM SHALL then enter WAIT. Code 11 SHALL pulse error and enter RELEASE.
REQ-009 WAIT: slave_en SHALL be one-hot on the selected slave. The selected ready high SHALL enter CONNECT next cycle.
REQ-010 WAIT timeout: a counter SHALL clear on WAIT entry. After TIMEOUT cycles in WAIT with ready low, the FSM SHALL pulse error and enter RELEASE.
REQ-011 CONNECT: grant and slave_en SHALL stay asserted while the owner's request is high. Request low SHALL enter RELEASE.
REQ-012 RELEASE: the FSM SHALL spend exactly one cycle with grants and slave_en at 0. It SHALL record the last-granted master, then go to IDLE.
REQ-013 Request dropped in ADDR or WAIT: the FSM SHALL abort to RELEASE with no error.
REQ-014 slave_sel SHALL hold the last decoded value until the next decode.

Reset
REQ-015 Reset SHALL force IDLE and clear all outputs to 0.
REQ-016 Reset SHALL clear the shift register, the timeout counter and the split record, and set last-granted = m2 so that m1 wins the first tie.
REQ-017 Reset asserted mid-transaction SHALL override every transition on that edge.

Configuration
REQ-018 Macro BUS_GRANT_SPLIT_EN SHALL enable split transactions.
REQ-019 With the macro defined:
- In CONNECT, a selected slave hold high SHALL enter SPLIT.
- SPLIT SHALL drop grant and slave_en, save the owner and slave index, and go to IDLE next cycle.
- While the split is pending, the split owner SHALL be excluded from arbitration.
- When the saved slave's hold falls and the FSM is in IDLE, the FSM SHALL re-grant the saved owner straight into CONNECT with the saved slave_en, with priority over new requests.
- The split record SHALL then clear.
REQ-020 Without the macro, hold inputs SHALL be ignored and the SPLIT state SHALL be unreachable.

Verification
REQ-021 m1 alone, addr bits 0,1, s2_ready high after 3 cycles -> m1_grant high, slave_en=010, slave_sel=1, CONNECT. m1_request low -> RELEASE for 1 cycle -> IDLE.
REQ-022 Both requests in the same cycle after reset -> m1 wins. After its release with m2 still requesting and m1 re-requesting -> m2 wins.
REQ-023 Addr 1,1 -> error high for exactly 1 cycle, RELEASE, no slave_en asserted.
REQ-024 Addr 1,0 with s3_ready held low, TIMEOUT=200 -> error pulses on the 200th WAIT cycle, then RELEASE.
REQ-025 Macro on: m1 in CONNECT with s1, s1_hold high -> SPLIT, m1_grant low; m2 completes a transaction to s3; s1_hold low -> m1_grant high in CONNECT with slave_en=001, without passing through ADDR.
REQ-026 Reset pulsed while in WAIT -> next cycle state=0 and all outputs 0; a subsequent tie -> m1 granted.
